// File: rtl/cam_pkg.sv
// Shared definitions for the camera stream transmitter: RGB565 colours,
// test-pattern selection, FSM state encoding and default frame geometry.
package cam_pkg;

  localparam int unsigned SCREEN_WIDTH_DEF  = 176;
  localparam int unsigned SCREEN_HEIGHT_DEF = 144;

  localparam logic [15:0] RGB_WHITE   = 16'hFFFF;
  localparam logic [15:0] RGB_YELLOW  = 16'hFFE0;
  localparam logic [15:0] RGB_CYAN    = 16'h07FF;
  localparam logic [15:0] RGB_GREEN   = 16'h07E0;
  localparam logic [15:0] RGB_MAGENTA = 16'hF81F;
  localparam logic [15:0] RGB_RED     = 16'hF800;
  localparam logic [15:0] RGB_BLUE    = 16'h001F;
  localparam logic [15:0] RGB_BLACK   = 16'h0000;

  typedef enum logic [1:0] {
    PAT_EXTERNAL = 2'd0,
    PAT_BARS     = 2'd1,
    PAT_RED      = 2'd2,
    PAT_DIAG     = 2'd3
  } pattern_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_VSYNC  = 3'd1,
    ST_VBACK  = 3'd2,
    ST_LINE   = 3'd3,
    ST_HBLANK = 3'd4,
    ST_VFRONT = 3'd5
  } state_e;

  // Colour of bar idx, left to right
  function automatic logic [15:0] bar_colour(input logic [2:0] idx);
    logic [15:0] c;
    case (idx)
      3'd0:    c = RGB_WHITE;
      3'd1:    c = RGB_YELLOW;
      3'd2:    c = RGB_CYAN;
      3'd3:    c = RGB_GREEN;
      3'd4:    c = RGB_MAGENTA;
      3'd5:    c = RGB_RED;
      3'd6:    c = RGB_BLUE;
      default: c = RGB_BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/cam_pattern_gen.sv
// Combinational test-pattern source: maps pixel coordinates and pattern
// selection to an RGB565 word. External mode yields zero (the top muxes in
// the fetched word instead).
module cam_pattern_gen
  import cam_pkg::*;
#(
  parameter int unsigned SCREEN_WIDTH = SCREEN_WIDTH_DEF
) (
  input  logic [7:0]  i_x,
  input  logic [7:0]  i_y,
  input  pattern_e    i_sel,
  output logic [15:0] o_rgb
);

  localparam int unsigned BAR_W   = ((SCREEN_WIDTH / 8) > 0) ? (SCREEN_WIDTH / 8) : 1;
  localparam logic [7:0]  C_BAR_W = 8'(BAR_W);

  logic [7:0] w_bar_raw;
  logic [2:0] w_bar;

  // Bar index from x; widths that do not divide by 8 fold the remainder into the last bar
  always_comb begin
    w_bar_raw = i_x / C_BAR_W;
    if (w_bar_raw > 8'd7) begin
      w_bar = 3'd7;
    end else begin
      w_bar = w_bar_raw[2:0];
    end
  end

  // Colour selection per pattern
  always_comb begin
    o_rgb = RGB_BLACK;
    case (i_sel)
      PAT_BARS: o_rgb = bar_colour(w_bar);
      PAT_RED:  o_rgb = RGB_RED;
      PAT_DIAG: begin
        if (i_x == i_y) begin
          o_rgb = RGB_RED;
        end else begin
          o_rgb = RGB_GREEN;
        end
      end
      default:  o_rgb = RGB_BLACK;
    endcase
  end

endmodule

// File: rtl/camera_stream_tx.sv
// Camera-side transmitter: emits PCLK/HREF/VSYNC/DATA frames of RGB565 pixels
// as byte pairs, sourcing pixels from an external one-cycle-latency memory or
// an internal test pattern. All camera-side state moves on the CLK edge where
// PCLK_OUT falls, so outputs are stable at PCLK_OUT rising.
module camera_stream_tx
  import cam_pkg::*;
#(
  parameter int unsigned SCREEN_WIDTH  = SCREEN_WIDTH_DEF,
  parameter int unsigned SCREEN_HEIGHT = SCREEN_HEIGHT_DEF,
  parameter int unsigned HBLANK        = 16,
  parameter int unsigned VSYNC_LINES   = 3,
  parameter int unsigned VBACK_LINES   = 2,
  parameter int unsigned VFRONT_LINES  = 2
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_en,
  input  logic [1:0]  i_pattern_sel,
  output logic        o_pix_req,
  output logic [7:0]  o_pix_x,
  output logic [7:0]  o_pix_y,
  input  logic [15:0] i_pix_data,
  output logic        o_pclk_out,
  output logic        o_href,
  output logic        o_vsync,
  output logic [7:0]  o_data,
  output logic        o_frame_done
);

  localparam int unsigned LINE_BYTES = 2 * SCREEN_WIDTH;
  localparam int unsigned LINE_TIME  = LINE_BYTES + HBLANK;

  // Counter terminal values; *_PRE is one PCLK early, where pixel 0 of the next line is fetched
  localparam logic [15:0] C_BYTE_LAST = 16'(LINE_BYTES - 1);
  localparam logic [15:0] C_REQ_LIMIT = 16'(LINE_BYTES - 2);
  localparam logic [15:0] C_HB_LAST   = 16'(HBLANK - 1);
  localparam logic [15:0] C_HB_PRE    = 16'(HBLANK - 2);
  localparam logic [15:0] C_LT_LAST   = 16'(LINE_TIME - 1);
  localparam logic [15:0] C_LT_PRE    = 16'(LINE_TIME - 2);
  localparam logic [7:0]  C_VS_LAST   = 8'(VSYNC_LINES - 1);
  localparam logic [7:0]  C_VB_LAST   = 8'(VBACK_LINES - 1);
  localparam logic [7:0]  C_VF_LAST   = 8'(VFRONT_LINES - 1);
  localparam logic [7:0]  C_Y_LAST    = 8'(SCREEN_HEIGHT - 1);

  state_e      r_state;
  pattern_e    r_mode;
  logic        r_pclk;
  logic [15:0] r_cnt;
  logic [7:0]  r_vline;
  logic [7:0]  r_y;
  logic [7:0]  r_lo;
  logic        r_href;
  logic        r_vsync;
  logic [7:0]  r_data;
  logic        r_pix_req;
  logic [7:0]  r_pix_x;
  logic [7:0]  r_pix_y;
  logic        r_frame_done;

  logic [15:0] w_pat;
  logic [15:0] w_pixel;

  cam_pattern_gen #(
    .SCREEN_WIDTH (SCREEN_WIDTH)
  ) u_pattern (
    .i_x   (r_pix_x),
    .i_y   (r_pix_y),
    .i_sel (r_mode),
    .o_rgb (w_pat)
  );

  // Pixel source: the fetched word in external mode, otherwise the generated pattern
  always_comb begin
    w_pixel = w_pat;
    if (r_mode == PAT_EXTERNAL) begin
      w_pixel = i_pix_data;
    end else begin
      w_pixel = w_pat;
    end
  end

  // Phase bit, frame FSM, counters, fetch strobe and byte mux, advanced on PCLK falling edges
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state      <= ST_IDLE;
      r_mode       <= PAT_EXTERNAL;
      r_pclk       <= 1'b0;
      r_cnt        <= 16'd0;
      r_vline      <= 8'd0;
      r_y          <= 8'd0;
      r_lo         <= 8'd0;
      r_href       <= 1'b0;
      r_vsync      <= 1'b0;
      r_data       <= 8'd0;
      r_pix_req    <= 1'b0;
      r_pix_x      <= 8'd0;
      r_pix_y      <= 8'd0;
      r_frame_done <= 1'b0;
    end else begin
      r_pclk       <= ~r_pclk;
      r_pix_req    <= 1'b0;
      r_frame_done <= 1'b0;
      if (r_pclk) begin
        case (r_state)
          ST_IDLE: begin
            if (i_en) begin
              r_state <= ST_VSYNC;
              r_vsync <= 1'b1;
              r_cnt   <= 16'd0;
              r_vline <= 8'd0;
              r_y     <= 8'd0;
              r_mode  <= pattern_e'(i_pattern_sel);
            end
          end
          ST_VSYNC: begin
            if (r_cnt == C_LT_LAST) begin
              r_cnt <= 16'd0;
              if (r_vline == C_VS_LAST) begin
                r_state <= ST_VBACK;
                r_vsync <= 1'b0;
                r_vline <= 8'd0;
              end else begin
                r_vline <= r_vline + 8'd1;
              end
            end else begin
              r_cnt <= r_cnt + 16'd1;
            end
          end
          ST_VBACK: begin
            if (r_cnt == C_LT_LAST && r_vline == C_VB_LAST) begin
              r_state <= ST_LINE;
              r_cnt   <= 16'd0;
              r_href  <= 1'b1;
              r_data  <= w_pixel[15:8];
              r_lo    <= w_pixel[7:0];
            end else if (r_cnt == C_LT_LAST) begin
              r_cnt   <= 16'd0;
              r_vline <= r_vline + 8'd1;
            end else begin
              r_cnt <= r_cnt + 16'd1;
              if (r_cnt == C_LT_PRE && r_vline == C_VB_LAST) begin
                r_pix_req <= (r_mode == PAT_EXTERNAL);
                r_pix_x   <= 8'd0;
                r_pix_y   <= 8'd0;
              end
            end
          end
          ST_LINE: begin
            if (r_cnt == C_BYTE_LAST) begin
              r_state <= ST_HBLANK;
              r_cnt   <= 16'd0;
              r_href  <= 1'b0;
              r_data  <= 8'd0;
            end else begin
              r_cnt <= r_cnt + 16'd1;
              if (r_cnt[0]) begin
                r_data <= w_pixel[15:8];
                r_lo   <= w_pixel[7:0];
              end else begin
                r_data <= r_lo;
                // Fetch the next pixel while its predecessor's low byte goes out
                if (r_cnt < C_REQ_LIMIT) begin
                  r_pix_req <= (r_mode == PAT_EXTERNAL);
                  r_pix_x   <= r_pix_x + 8'd1;
                  r_pix_y   <= r_y;
                end
              end
            end
          end
          ST_HBLANK: begin
            if (r_cnt == C_HB_LAST) begin
              r_cnt <= 16'd0;
              if (r_y == C_Y_LAST) begin
                r_state <= ST_VFRONT;
                r_vline <= 8'd0;
              end else begin
                r_state <= ST_LINE;
                r_y     <= r_y + 8'd1;
                r_href  <= 1'b1;
                r_data  <= w_pixel[15:8];
                r_lo    <= w_pixel[7:0];
              end
            end else begin
              r_cnt <= r_cnt + 16'd1;
              if (r_cnt == C_HB_PRE && r_y != C_Y_LAST) begin
                r_pix_req <= (r_mode == PAT_EXTERNAL);
                r_pix_x   <= 8'd0;
                r_pix_y   <= r_y + 8'd1;
              end
            end
          end
          ST_VFRONT: begin
            if (r_cnt == C_LT_LAST && r_vline == C_VF_LAST) begin
              r_frame_done <= 1'b1;
              r_cnt        <= 16'd0;
              r_vline      <= 8'd0;
              r_y          <= 8'd0;
              if (i_en) begin
                r_state <= ST_VSYNC;
                r_vsync <= 1'b1;
                r_mode  <= pattern_e'(i_pattern_sel);
              end else begin
                r_state <= ST_IDLE;
              end
            end else if (r_cnt == C_LT_LAST) begin
              r_cnt   <= 16'd0;
              r_vline <= r_vline + 8'd1;
            end else begin
              r_cnt <= r_cnt + 16'd1;
            end
          end
          default: begin
            r_state <= ST_IDLE;
            r_href  <= 1'b0;
            r_vsync <= 1'b0;
            r_data  <= 8'd0;
          end
        endcase
      end
    end
  end

  assign o_pclk_out   = r_pclk;
  assign o_href       = r_href;
  assign o_vsync      = r_vsync;
  assign o_data       = r_data;
  assign o_pix_req    = r_pix_req;
  assign o_pix_x      = r_pix_x;
  assign o_pix_y      = r_pix_y;
  assign o_frame_done = r_frame_done;

endmodule
